pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 4-register in-order pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It drives the `stall` and `flush` inputs of every pipeline register. It resolves three hazards:

- memory-wait back-pressure;
- load-use interlock;
- EX-stage branch redirect.

A wait-timeout watchdog halts the pipe on a hung memory access.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush control for a 4-register in-order pipeline.
// Optional stall counter enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_src_a_idx,
  input  logic       id_src_a_use,
  input  logic [2:0] id_src_b_idx,
  input  logic       id_src_b_use,
  input  logic       ex_valid,
  input  logic [2:0] ex_dst_idx,
  input  logic       ex_is_load,
  input  logic       ex_redirect,
  input  logic       mem_valid,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       stall_fd,
  output logic       stall_de,
  output logic       stall_em,
  output logic       stall_mw,
  output logic       flush_fd,
  output logic       flush_de,
  output logic       flush_em,
  output logic       flush_mw,
  output logic [1:0] state,
  output logic       mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        timeout_q, timeout_d;
  logic        mem_hold;
  logic        lu_hit;
  logic        redirect;

  assign mem_hold = mem_valid & mem_req & ~mem_ready;
  assign lu_hit   = id_valid & ex_valid & ex_is_load &
                    ((id_src_a_use & (id_src_a_idx == ex_dst_idx)) |
                     (id_src_b_use & (id_src_b_idx == ex_dst_idx)));
  assign redirect = ex_valid & ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        // Completion beats the watchdog when both happen on the last count.
        if (mem_ready || !mem_valid) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    stall_fd = 1'b0;
    stall_de = 1'b0;
    stall_em = 1'b0;
    stall_mw = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    flush_mw = 1'b0;
    if (state_q == ST_HALT) begin
      stall_fd = 1'b1;
      stall_de = 1'b1;
      stall_em = 1'b1;
      stall_mw = 1'b1;
    end else if (mem_hold) begin
      // Bubble into WB so the frozen MEM instruction is not written back twice.
      stall_fd = 1'b1;
      stall_de = 1'b1;
      stall_em = 1'b1;
      flush_mw = 1'b1;
    end else if (redirect) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (lu_hit) begin
      stall_fd = 1'b1;
      flush_de = 1'b1;
    end
  end

  assign state       = state_q;
  assign mem_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall_fd && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl (TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_src_a_use, id_src_b_use;
  logic [2:0] id_src_a_idx, id_src_b_idx, ex_dst_idx;
  logic       ex_valid, ex_is_load, ex_redirect;
  logic       mem_valid, mem_req, mem_ready;
  logic       stall_fd, stall_de, stall_em, stall_mw;
  logic       flush_fd, flush_de, flush_em, flush_mw;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src_a_idx (id_src_a_idx),
    .id_src_a_use (id_src_a_use),
    .id_src_b_idx (id_src_b_idx),
    .id_src_b_use (id_src_b_use),
    .ex_valid     (ex_valid),
    .ex_dst_idx   (ex_dst_idx),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_valid    (mem_valid),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .stall_fd     (stall_fd),
    .stall_de     (stall_de),
    .stall_em     (stall_em),
    .stall_mw     (stall_mw),
    .flush_fd     (flush_fd),
    .flush_de     (flush_de),
    .flush_em     (flush_em),
    .flush_mw     (flush_mw),
    .state        (state),
    .mem_timeout  (mem_timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de, flush_em, flush_mw}
  logic [7:0] ctl;
  assign ctl = {stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de, flush_em, flush_mw};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_src_a_idx = 0; id_src_a_use = 0; id_src_b_idx = 0; id_src_b_use = 0;
    ex_valid = 0; ex_dst_idx = 0; ex_is_load = 0; ex_redirect = 0;
    mem_valid = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 0;
    step();
    do_reset();

    // Reset state
    sample();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", 32'(ctl), 32'h00);
    check("rst_timeout", 32'(mem_timeout), 32'd0);

    // Load-use on source B
    step();
    ex_valid = 1; ex_is_load = 1; ex_dst_idx = 3; id_valid = 1; id_src_b_use = 1; id_src_b_idx = 3;
    sample();
    check("lu_b_hit", 32'(ctl), 32'h84);
    step();
    id_src_b_idx = 4;
    sample();
    check("lu_b_miss", 32'(ctl), 32'h00);
    // Source A match, B unused
    step();
    id_src_b_use = 0; id_src_a_use = 1; id_src_a_idx = 3;
    sample();
    check("lu_a_hit", 32'(ctl), 32'h84);
    // Index 0 is an ordinary register
    step();
    id_src_a_idx = 0; ex_dst_idx = 0;
    sample();
    check("lu_idx0", 32'(ctl), 32'h84);
    // Not a load: no interlock
    step();
    ex_is_load = 0;
    sample();
    check("lu_noload", 32'(ctl), 32'h00);
    // Redirect overrides load-use
    step();
    ex_is_load = 1; ex_redirect = 1;
    sample();
    check("redir_lu", 32'(ctl), 32'h0C);

    // 3-cycle memory wait with a concurrent redirect
    step();
    idle();
    ex_valid = 1; ex_redirect = 1; mem_valid = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("mw_ctl_%0d", i), 32'(ctl), 32'hE1);
      check($sformatf("mw_state_%0d", i), 32'(state), (i == 0) ? 32'd0 : 32'd1);
      step();
    end
    mem_ready = 1;
    sample();
    check("mw_done_ctl", 32'(ctl), 32'h0C);
    check("mw_done_state", 32'(state), 32'd1);
    step();
    idle();
    sample();
    check("mw_back_run", 32'(state), 32'd0);

    // Completion on the last allowed count beats the watchdog
    step();
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    step(); step(); step();
    mem_ready = 1;
    sample();
    check("edge_state", 32'(state), 32'd1);
    check("edge_ctl", 32'(ctl), 32'h00);
    step();
    idle();
    sample();
    check("edge_run", 32'(state), 32'd0);
    check("edge_no_to", 32'(mem_timeout), 32'd0);

    // Watchdog: 4 hold cycles then HALT
    step();
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("to_pre_%0d", i), 32'(mem_timeout), 32'd0);
      step();
    end
    sample();
    check("halt_state", 32'(state), 32'd2);
    check("halt_ctl", 32'(ctl), 32'hF0);
    check("halt_to", 32'(mem_timeout), 32'd1);
    step();
    idle();
    mem_valid = 1; mem_ready = 1; ex_valid = 1; ex_redirect = 1;
    sample();
    check("halt_sticky", 32'(state), 32'd2);
    check("halt_sticky_ctl", 32'(ctl), 32'hF0);
    step();
    do_reset();
    sample();
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_to", 32'(mem_timeout), 32'd0);
    check("halt_rst_ctl", 32'(ctl), 32'h00);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // 3 memory stall cycles + 1 load-use stall
    step();
    do_reset();
    sample();
    check("perf_rst0", perf_stall_cnt, 32'd0);
    step();
    mem_valid = 1; mem_req = 1; mem_ready = 0;
    step(); step(); step();
    mem_ready = 1;
    step();
    idle();
    ex_valid = 1; ex_is_load = 1; ex_dst_idx = 5; id_valid = 1; id_src_a_use = 1; id_src_a_idx = 5;
    step();
    idle();
    step();
    sample();
    check("perf_cnt", perf_stall_cnt, 32'd4);
    step();
    do_reset();
    sample();
    check("perf_rst", perf_stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
